// File: rtl/bh_render_pipe.sv
// bh_render_pipe: three-stage black-hole scene renderer (belt, shadow, halo, falling text) for 640x480 VGA.
// Define BH_TEXT_EN to build the falling-text FSM and glyph overlay; without it text never draws.
module bh_render_pipe #(
  parameter int COLOR_BITS  = 2,
  parameter int CX          = 320,
  parameter int CY          = 240,
  parameter int SHADOW_R2   = 7225,
  parameter int BELT_IN_R2  = 10000,
  parameter int BELT_OUT_R2 = 85000,
  parameter int HALO_IN_R2  = 5000,
  parameter int HALO_OUT_R2 = 22000,
  parameter int FLAT_SHIFT  = 4,
  parameter int FRONT_DY    = 4,
  parameter int TEXT_Y0     = 20,
  parameter int TEXT_Y_END  = 275,
  parameter int WAIT_FRAMES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            hpos,
  input  logic [9:0]            vpos,
  input  logic                  display_on,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic [1:0]            speed,
  input  logic                  pause,
  output logic [COLOR_BITS-1:0] r,
  output logic [COLOR_BITS-1:0] g,
  output logic [COLOR_BITS-1:0] b,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic [15:0]           frame_cnt
);

  localparam int CB = COLOR_BITS;
  localparam logic [CB-1:0] C_FULL = '1;
  localparam logic [CB-1:0] C_HALF = {1'b1, {(CB-1){1'b0}}};
  localparam logic [CB-1:0] C_DIM  = CB'(1);
  localparam logic [CB-1:0] C_NONE = '0;
  localparam logic signed [10:0] FRONT_LIM = 11'(FRONT_DY);

  // ---------------- frame tick, frame counter, animation phase ----------------
  logic       vsync_q;
  logic       tick;
  logic [7:0] anim;

  assign tick = vsync_in & ~vsync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q   <= 1'b1;
      frame_cnt <= '0;
      anim      <= '0;
    end else begin
      vsync_q <= vsync_in;
      if (tick) frame_cnt <= frame_cnt + 16'd1;
      if (tick && !pause) anim <= anim + (8'd1 << speed);
    end
  end

  // ---------------- stage 1: centred coordinates ----------------
  logic signed [10:0] dx_s1, dy_s1;
  logic               de_s1, hs_s1, vs_s1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dx_s1 <= '0;
      dy_s1 <= '0;
      de_s1 <= 1'b0;
      hs_s1 <= 1'b1;
      vs_s1 <= 1'b1;
    end else begin
      dx_s1 <= $signed({1'b0, hpos} - 11'(CX));
      dy_s1 <= $signed({1'b0, vpos} - 11'(CY));
      de_s1 <= display_on;
      hs_s1 <= hsync_in;
      vs_s1 <= vsync_in;
    end
  end

  // ---------------- stage 2: circular and flattened radii ----------------
  logic [21:0]        dx_sq, dy_sq;
  logic [23:0]        r2c_s2, r2f_s2;
  logic signed [10:0] dy_s2;
  logic               de_s2, hs_s2, vs_s2;

  assign dx_sq = $unsigned(22'(dx_s1) * 22'(dx_s1));
  assign dy_sq = $unsigned(22'(dy_s1) * 22'(dy_s1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r2c_s2 <= '0;
      r2f_s2 <= '0;
      dy_s2  <= '0;
      de_s2  <= 1'b0;
      hs_s2  <= 1'b1;
      vs_s2  <= 1'b1;
    end else begin
      r2c_s2 <= 24'(dx_sq) + 24'(dy_sq);
      r2f_s2 <= 24'(dx_sq) + (24'(dy_sq) << FLAT_SHIFT);
      dy_s2  <= dy_s1;
      de_s2  <= de_s1;
      hs_s2  <= hs_s1;
      vs_s2  <= vs_s1;
    end
  end

  // ---------------- text overlay ----------------
  logic text_pix;

`ifdef BH_TEXT_EN
  // state   | meaning
  // ST_WAIT | text parked at TEXT_Y0, wcnt counts frame ticks
  // ST_FALL | text_y moves down one row per tick until TEXT_Y_END
  typedef enum logic {ST_WAIT, ST_FALL} text_state_t;

  localparam logic [10:0] U_X0 = 11'(CX - 28);
  localparam logic [10:0] W_X0 = 11'(CX + 4);

  text_state_t state, state_nx;
  logic [15:0] wcnt, wcnt_nx;
  logic [9:0]  text_y, text_y_nx;
  logic [9:0]  h_s1, v_s1, h_s2, v_s2;
  logic [9:0]  row_off;
  logic [10:0] ucol, wcol;

  function automatic logic glyph(input logic [4:0] col, input logic [4:0] row,
                                 input logic centre);
    glyph = (col < 5'd4) || (col > 5'd19) || (row > 5'd27) ||
            (centre && col >= 5'd10 && col <= 5'd13 && row >= 5'd16);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_WAIT;
      wcnt   <= '0;
      text_y <= 10'(TEXT_Y0);
    end else begin
      state  <= state_nx;
      wcnt   <= wcnt_nx;
      text_y <= text_y_nx;
    end
  end

  // WAIT leaves as soon as the count is reached; FALL only moves on ticks.
  always_comb begin
    state_nx  = state;
    wcnt_nx   = wcnt;
    text_y_nx = text_y;
    if (!pause) begin
      case (state)
        ST_WAIT: begin
          text_y_nx = 10'(TEXT_Y0);
          if (wcnt == 16'(WAIT_FRAMES)) begin
            state_nx = ST_FALL;
            wcnt_nx  = '0;
          end else if (tick) begin
            wcnt_nx = wcnt + 16'd1;
          end
        end
        ST_FALL: begin
          if (tick) begin
            if (text_y == 10'(TEXT_Y_END)) begin
              state_nx  = ST_WAIT;
              text_y_nx = 10'(TEXT_Y0);
            end else begin
              text_y_nx = text_y + 10'd1;
            end
          end
        end
        default: state_nx = ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_s1 <= '0;
      v_s1 <= '0;
      h_s2 <= '0;
      v_s2 <= '0;
    end else begin
      h_s1 <= hpos;
      v_s1 <= vpos;
      h_s2 <= h_s1;
      v_s2 <= v_s1;
    end
  end

  // Wrapping subtraction turns "left of / above the glyph" into a large offset.
  assign row_off = v_s2 - text_y;
  assign ucol    = {1'b0, h_s2} - U_X0;
  assign wcol    = {1'b0, h_s2} - W_X0;

  always_comb begin
    text_pix = 1'b0;
    if (row_off < 10'd32) begin
      if (ucol < 11'd24)
        text_pix = glyph(ucol[4:0], row_off[4:0], 1'b0);
      else if (wcol < 11'd24)
        text_pix = glyph(wcol[4:0], row_off[4:0], 1'b1);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{10'(TEXT_Y0), 10'(TEXT_Y_END), 16'(WAIT_FRAMES)};
  assign text_pix   = 1'b0;
`endif

  // ---------------- stage 3: regions, textures, colour ----------------
  logic [7:0]      belt_tex, halo_tex;
  logic            in_belt, in_halo, in_shadow, front;
  logic [3*CB-1:0] pix;

  function automatic logic [3*CB-1:0] shade(input logic [7:0] tex);
    if (tex[4])      shade = {C_DIM,  C_NONE, C_NONE};
    else if (tex[2]) shade = {C_FULL, C_HALF, C_NONE};
    else             shade = {C_FULL, C_NONE, C_NONE};
  endfunction

  assign belt_tex  = r2f_s2[15:8] - anim;
  assign halo_tex  = r2c_s2[13:6] - anim;
  assign in_belt   = (r2f_s2 >= 24'(BELT_IN_R2)) && (r2f_s2 <= 24'(BELT_OUT_R2));
  assign in_halo   = (r2c_s2 >= 24'(HALO_IN_R2)) && (r2c_s2 <= 24'(HALO_OUT_R2));
  assign in_shadow = r2c_s2 < 24'(SHADOW_R2);
  assign front     = dy_s2 > FRONT_LIM;

  always_comb begin
    pix = '0;
    if (!de_s2)               pix = '0;
    else if (in_belt && front) pix = shade(belt_tex);
    else if (in_shadow)        pix = '0;
    else if (text_pix)         pix = '1;
    else if (in_belt)          pix = shade(belt_tex);
    else if (in_halo)          pix = shade(halo_tex);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r         <= '0;
      g         <= '0;
      b         <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      {r, g, b} <= pix;
      hsync_out <= hs_s2;
      vsync_out <= vs_s2;
    end
  end

endmodule

// File: tb/tb_bh_render_pipe.sv
// Self-checking bench for bh_render_pipe: hand-computed vectors, latency/reset/animation sequences,
// randomized pixels against a geometric reference model; text checks adapt to BH_TEXT_EN.
module tb_bh_render_pipe;

`ifdef BH_TEXT_EN
  localparam bit TEXT_EN = 1'b1;
`else
  localparam bit TEXT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] hpos, vpos;
  logic       display_on, hsync_in, vsync_in, pause;
  logic [1:0] speed;
  logic [1:0] r, g, b;
  logic       hsync_out, vsync_out;
  logic [15:0] frame_cnt;

  bh_render_pipe dut (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .speed(speed), .pause(pause),
    .r(r), .g(g), .b(b), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // reference state: animation phase, frame count, unpaused tick count
  int m_anim  = 0;
  int m_frame = 0;
  int m_t     = 0;

  typedef struct {
    int         h;
    int         v;
    bit         de;
    logic [5:0] exp_rgb;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] tex_col(input int base, input int an);
    int t;
    t = ((base % 256) - an + 256) % 256;
    if ((t / 16) % 2 == 1) return 6'b01_00_00;
    if ((t / 4) % 2 == 1)  return 6'b11_10_00;
    return 6'b11_00_00;
  endfunction

  // Text row from the number of unpaused ticks: 255 in WAIT, then 256 ticks of FALL.
  function automatic int model_ty();
    int p;
    p = m_t % 511;
    if (p >= 255) return 20 + (p - 255);
    return 20;
  endfunction

  function automatic bit model_text(input int h, input int v, input int ty);
    int row, col;
    if (!TEXT_EN || v < ty || v >= ty + 32) return 1'b0;
    row = v - ty;
    if (h >= 292 && h <= 315) begin
      col = h - 292;
      return col < 4 || col > 19 || row > 27;
    end
    if (h >= 324 && h <= 347) begin
      col = h - 324;
      return col < 4 || col > 19 || row > 27 || (col >= 10 && col <= 13 && row >= 16);
    end
    return 1'b0;
  endfunction

  function automatic logic [5:0] model_pix(input int h, input int v, input bit de,
                                           input int an, input int ty);
    int dx, dy, r2c, r2f;
    bit belt, halo, shadow;
    if (!de) return 6'd0;
    dx = h - 320;
    dy = v - 240;
    r2c = dx * dx + dy * dy;
    r2f = dx * dx + 16 * dy * dy;
    belt   = r2f >= 10000 && r2f <= 85000;
    halo   = r2c >= 5000 && r2c <= 22000;
    shadow = r2c < 7225;
    if (belt && dy > 4)        return tex_col(r2f / 256, an);
    if (shadow)                return 6'd0;
    if (model_text(h, v, ty))  return 6'h3f;
    if (belt)                  return tex_col(r2f / 256, an);
    if (halo)                  return tex_col(r2c / 64, an);
    return 6'd0;
  endfunction

  task automatic drive_pix(input int h, input int v, input bit de);
    hpos = 10'(h);
    vpos = 10'(v);
    display_on = de;
  endtask

  task automatic check_pix(input string nm, input int h, input int v, input bit de);
    logic [5:0] e;
    drive_pix(h, v, de);
    e = model_pix(h, v, de, m_anim, model_ty());
    repeat (3) step();
    chk(nm, int'({r, g, b}), int'(e));
  endtask

  // One vsync low pulse; pause takes its new value on the same cycle as the rising edge.
  task automatic vpulse(input bit p);
    vsync_in = 1'b0;
    step();
    vsync_in = 1'b1;
    pause = p;
    m_frame++;
    if (!p) begin
      m_anim = (m_anim + (1 << speed)) % 256;
      m_t++;
    end
    step();
  endtask

  task automatic model_reset();
    m_anim = 0;
    m_frame = 0;
    m_t = 0;
  endtask

  logic [6:0] expq[$];

  initial begin
    rst_n = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    speed = 2'd0;
    pause = 1'b0;
    drive_pix(420, 240, 1'b1);

    vt[0]  = '{320, 240, 1'b1, 6'b00_00_00};
    vt[1]  = '{420, 240, 1'b1, 6'b11_10_00};
    vt[2]  = '{420, 240, 1'b0, 6'b00_00_00};
    vt[3]  = '{320, 265, 1'b1, 6'b11_10_00};
    vt[4]  = '{320, 215, 1'b1, 6'b00_00_00};
    vt[5]  = '{320, 125, 1'b1, 6'b11_10_00};
    vt[6]  = '{320, 120, 1'b1, 6'b11_00_00};
    vt[7]  = '{320, 140, 1'b1, 6'b01_00_00};
    vt[8]  = '{560, 240, 1'b1, 6'b11_00_00};
    vt[9]  = '{611, 240, 1'b1, 6'b11_00_00};
    vt[10] = '{612, 240, 1'b1, 6'b00_00_00};
    vt[11] = '{320, 325, 1'b1, 6'b01_00_00};
    vt[12] = '{320, 324, 1'b1, 6'b00_00_00};
    vt[13] = '{440, 240, 1'b1, 6'b01_00_00};
    vt[14] = '{0,   0,   1'b1, 6'b00_00_00};

    repeat (5) step();
    chk("reset_rgb", int'({r, g, b}), 0);
    chk("reset_hsync", int'(hsync_out), 1);
    chk("reset_vsync", int'(vsync_out), 1);
    chk("reset_frame", int'(frame_cnt), 0);
`ifdef BH_TEXT_EN
    chk("reset_text_y", int'(dut.text_y), 20);
`endif
    rst_n = 1'b1;
    model_reset();
    step();

    for (int i = 0; i < 15; i++) begin
      drive_pix(vt[i].h, vt[i].v, vt[i].de);
      repeat (3) step();
      chk($sformatf("vec%0d_rgb", i), int'({r, g, b}), int'(vt[i].exp_rgb));
    end

    // hsync latency: low for one cycle, seen on exactly the third edge
    hsync_in = 1'b0;
    step(); hsync_in = 1'b1;
    chk("hs_lat1", int'(hsync_out), 1);
    step(); chk("hs_lat2", int'(hsync_out), 1);
    step(); chk("hs_lat3", int'(hsync_out), 0);
    step(); chk("hs_lat4", int'(hsync_out), 1);

    vsync_in = 1'b0;
    step(); vsync_in = 1'b1;
    m_frame++; m_anim = (m_anim + (1 << speed)) % 256; m_t++;
    chk("vs_lat1", int'(vsync_out), 1);
    step(); chk("vs_lat2", int'(vsync_out), 1);
    step(); chk("vs_lat3", int'(vsync_out), 0);
    step(); chk("vs_lat4", int'(vsync_out), 1);
    chk("vs_frame", int'(frame_cnt), m_frame);

    // randomized pixels and hsync, streamed through a latency queue
    for (int i = 0; i < 400; i++) begin
      int h, v;
      bit de, hs;
      if (i % 2 == 0) begin h = $urandom_range(0, 799); v = $urandom_range(0, 524); end
      else begin h = $urandom_range(150, 620); v = $urandom_range(100, 380); end
      de = ($urandom_range(0, 7) != 0);
      hs = ($urandom_range(0, 3) != 0);
      drive_pix(h, v, de);
      hsync_in = hs;
      expq.push_back({hs, model_pix(h, v, de, m_anim, model_ty())});
      step();
      if (expq.size() == 3) begin
        logic [6:0] e;
        e = expq.pop_front();
        chk("rand_rgb", int'({r, g, b}), int'(e[5:0]));
        chk("rand_hsync", int'(hsync_out), int'(e[6]));
      end
    end
    hsync_in = 1'b1;

    // mid-frame reset
    speed = 2'd1;
    vpulse(1'b0);
    drive_pix(420, 240, 1'b1);
    hsync_in = 1'b0;
    repeat (3) step();
    chk("pre_rst_rgb", int'({r, g, b}), int'(model_pix(420, 240, 1'b1, m_anim, model_ty())));
    chk("pre_rst_hsync", int'(hsync_out), 0);
    rst_n = 1'b0;
    step();
    chk("mid_rst_rgb", int'({r, g, b}), 0);
    chk("mid_rst_hsync", int'(hsync_out), 1);
    chk("mid_rst_frame", int'(frame_cnt), 0);
    rst_n = 1'b1;
    model_reset();
    step(); chk("post_rst1_rgb", int'({r, g, b}), 0); chk("post_rst1_hs", int'(hsync_out), 1);
    step(); chk("post_rst2_rgb", int'({r, g, b}), 0); chk("post_rst2_hs", int'(hsync_out), 1);
    step(); chk("post_rst3_rgb", int'({r, g, b}), int'(6'b11_10_00));
    chk("post_rst3_hs", int'(hsync_out), 0);
    hsync_in = 1'b1;

    // animation: speed 2, three ticks -> phase 12; paused ticks only count frames
    speed = 2'd2;
    repeat (3) vpulse(1'b0);
    chk("anim_frame3", int'(frame_cnt), 3);
    check_pix("anim12_440", 440, 240, 1'b1);
    chk("anim12_440_const", int'({r, g, b}), int'(6'b11_10_00));
    check_pix("anim12_420", 420, 240, 1'b1);
    chk("anim12_420_const", int'({r, g, b}), int'(6'b01_00_00));
    pause = 1'b1;
    repeat (2) vpulse(1'b1);
    chk("pause_frame5", int'(frame_cnt), 5);
    check_pix("pause_440", 440, 240, 1'b1);
    chk("pause_440_const", int'({r, g, b}), int'(6'b11_10_00));
    vpulse(1'b0);
    chk("unpause_frame6", int'(frame_cnt), 6);
    check_pix("anim16_440", 440, 240, 1'b1);
    chk("anim16_440_const", int'({r, g, b}), int'(6'b11_00_00));

    // text FSM: restart from reset so tick counts are absolute
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_reset();
    step();
    speed = 2'd0;
    repeat (255) vpulse(1'b0);
`ifdef BH_TEXT_EN
    chk("wait_done_text_y", int'(dut.text_y), 20);
`endif
    vpulse(1'b0);
`ifdef BH_TEXT_EN
    chk("fall1_text_y", int'(dut.text_y), 21);
`endif
    check_pix("text_u_corner", 292, 21, 1'b1);
    chk("text_u_corner_const", int'({r, g, b}), TEXT_EN ? 63 : 0);
    check_pix("text_above", 292, 20, 1'b1);
    check_pix("text_w_bar", 334, 37, 1'b1);
    check_pix("text_w_nobar", 334, 36, 1'b1);
    vpulse(1'b1);
`ifdef BH_TEXT_EN
    chk("pause_text_y", int'(dut.text_y), 21);
`endif
    check_pix("pause_text_u", 292, 21, 1'b1);
    repeat (254) vpulse(1'b0);
`ifdef BH_TEXT_EN
    chk("fall_end_text_y", int'(dut.text_y), 275);
`endif
    check_pix("fall_end_pix", 300, 300, 1'b1);
    vpulse(1'b0);
`ifdef BH_TEXT_EN
    chk("rewait_text_y", int'(dut.text_y), 20);
`endif
    check_pix("rewait_u", 292, 21, 1'b1);
    check_pix("rewait_u_top", 295, 20, 1'b1);
    chk("final_frame", int'(frame_cnt), m_frame);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
